// File: rtl/mac_share_pkg.sv
// Shared widths, control-state encoding and id-width helper for the MAC share arbiter.
package mac_share_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_A_W   = 16;
  localparam int DEF_B_W   = 16;
  localparam int DEF_C_W   = 32;
  localparam int DEF_P_W   = 32;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DRAIN     = 2'd1,
    IDLE_HELD = 2'd2
  } ctrl_state_e;

  function automatic int idWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_share_arbiter_if.sv
// Requester handshake and shared response bus of the MAC share arbiter.
interface mac_share_arbiter_if
  import mac_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int C_W   = DEF_C_W,
  parameter int P_W   = DEF_P_W
) ();

  localparam int ID_W = idWidth(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic [N_REQ*C_W-1:0] req_c;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [P_W-1:0]       rsp_p;

  modport master (
    output req_valid, req_a, req_b, req_c,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/mac_share_arbiter_mac_pipe.sv
// Two-stage signed p = a*b + c pipeline carrying a valid/id sideband.
module signed_mac_pipe #(
  parameter int A_W  = 16,
  parameter int B_W  = 16,
  parameter int C_W  = 32,
  parameter int P_W  = 32,
  parameter int ID_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  input  logic [ID_W-1:0]        in_id_i,
  input  logic signed [A_W-1:0]  in_a_i,
  input  logic signed [B_W-1:0]  in_b_i,
  input  logic signed [C_W-1:0]  in_c_i,
  output logic                   out_valid_o,
  output logic [ID_W-1:0]        out_id_o,
  output logic [P_W-1:0]         out_p_o,
  output logic                   busy_o
);

  // Only the low P_W result bits are kept, so working at P_W after sign extension is exact.
  logic signed [P_W-1:0] aExt, bExt, cExt, sum;
  assign aExt = P_W'(in_a_i);
  assign bExt = P_W'(in_b_i);
  assign cExt = P_W'(in_c_i);
  assign sum  = aExt * bExt + cExt;

  logic            s0Valid_q, s1Valid_q;
  logic [ID_W-1:0] s0Id_q, s1Id_q;
  logic [P_W-1:0]  s0P_q, s1P_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0Valid_q <= 1'b0;
      s1Valid_q <= 1'b0;
      s0Id_q    <= '0;
      s1Id_q    <= '0;
      s0P_q     <= '0;
      s1P_q     <= '0;
    end else begin
      s0Valid_q <= in_valid_i;
      s1Valid_q <= s0Valid_q;
      if (in_valid_i) begin
        s0Id_q <= in_id_i;
        s0P_q  <= sum;
      end
      // Stage-1 data only moves with a valid op so the response bus holds its last result.
      if (s0Valid_q) begin
        s1Id_q <= s0Id_q;
        s1P_q  <= s0P_q;
      end
    end
  end

  assign out_valid_o = s1Valid_q;
  assign out_id_o    = s1Id_q;
  assign out_p_o     = s1P_q;
  assign busy_o      = s0Valid_q | s1Valid_q;

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter sharing one signed MAC pipeline among N_REQ requesters.
// Optional per-requester grant counters are enabled by defining MAC_SHARE_PERF_CNT_EN.
module mac_share_arbiter
  import mac_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int C_W   = DEF_C_W,
  parameter int P_W   = DEF_P_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_share_arbiter_if.slave   bus,
  input  logic                 hold,
  output logic                 busy
`ifdef MAC_SHARE_PERF_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [N_REQ*16-1:0]  grant_cnt
`endif
);

  localparam int ID_W = idWidth(N_REQ);
  localparam logic [1:0] ST_RUN       = 2'(RUN);
  localparam logic [1:0] ST_DRAIN     = 2'(DRAIN);
  localparam logic [1:0] ST_IDLE_HELD = 2'(IDLE_HELD);

  logic [ID_W-1:0]  rrLast_q, rrLast_d;
  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grantIdx;
  logic             handshake;

  // Scan from the lowest priority down so the final hit is the first valid after rrLast_q.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    if (!hold) begin
      for (int k = N_REQ; k >= 1; k--) begin
        if (bus.req_valid[(int'(rrLast_q) + k) % N_REQ]) begin
          grant = '0;
          grant[(int'(rrLast_q) + k) % N_REQ] = 1'b1;
          grantIdx = ID_W'((int'(rrLast_q) + k) % N_REQ);
        end
      end
    end
  end

  assign handshake     = |(bus.req_valid & grant);
  assign bus.req_ready = grant;
  assign rrLast_d      = handshake ? grantIdx : rrLast_q;

  always_comb begin
    state_d = ST_RUN;
    if (hold) begin
      case (state_q)
        ST_IDLE_HELD: state_d = ST_IDLE_HELD;
        default:      state_d = busy ? ST_DRAIN : ST_IDLE_HELD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrLast_q <= ID_W'(N_REQ - 1);
      state_q  <= ST_RUN;
    end else begin
      rrLast_q <= rrLast_d;
      state_q  <= state_d;
    end
  end

  logic signed [A_W-1:0] selA;
  logic signed [B_W-1:0] selB;
  logic signed [C_W-1:0] selC;
  assign selA = bus.req_a[int'(grantIdx)*A_W +: A_W];
  assign selB = bus.req_b[int'(grantIdx)*B_W +: B_W];
  assign selC = bus.req_c[int'(grantIdx)*C_W +: C_W];

  logic            pipeValid;
  logic [ID_W-1:0] pipeId;
  logic [P_W-1:0]  pipeP;

  signed_mac_pipe #(
    .A_W (A_W),
    .B_W (B_W),
    .C_W (C_W),
    .P_W (P_W),
    .ID_W(ID_W)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (handshake),
    .in_id_i    (grantIdx),
    .in_a_i     (selA),
    .in_b_i     (selB),
    .in_c_i     (selC),
    .out_valid_o(pipeValid),
    .out_id_o   (pipeId),
    .out_p_o    (pipeP),
    .busy_o     (busy)
  );

  assign bus.rsp_valid = pipeValid;
  assign bus.rsp_id    = pipeId;
  assign bus.rsp_p     = pipeP;

`ifdef MAC_SHARE_PERF_CNT_EN
  logic [N_REQ-1:0][15:0] cnt_q, cnt_d;

  // Clear takes precedence over a coincident handshake.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (cnt_clr)
        cnt_d[i] = '0;
      else if (grant[i] && bus.req_valid[i])
        cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed and random scoreboard bench for mac_share_arbiter (counters when MAC_SHARE_PERF_CNT_EN is set).
module tb_mac_share_arbiter;
  import mac_share_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int CW = 32;
  localparam int PW = 32;
  localparam int IW = idWidth(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic hold  = 1'b0;
  logic busy;
`ifdef MAC_SHARE_PERF_CNT_EN
  logic          cnt_clr = 1'b0;
  logic [N*16-1:0] grant_cnt;
  logic [15:0]   cntModel [N];
`endif

  mac_share_arbiter_if #(.N_REQ(N), .A_W(AW), .B_W(BW), .C_W(CW), .P_W(PW)) bus ();

  mac_share_arbiter #(.N_REQ(N), .A_W(AW), .B_W(BW), .C_W(CW), .P_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hold     (hold),
    .busy     (busy)
`ifdef MAC_SHARE_PERF_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] p;
  } exp_t;

  exp_t                 expQ [$];
  logic signed [AW-1:0] opA [N];
  logic signed [BW-1:0] opB [N];
  logic signed [CW-1:0] opC [N];
  logic [N-1:0]         valid;
  int                   nAsserts = 0;
  int                   nFail    = 0;
  int                   tbLast;
  logic [1:0]           hist;
  logic [IW-1:0]        lastId;
  logic [PW-1:0]        lastP;
  logic [1:0]           expState;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    bus.req_valid = valid;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*AW +: AW] = opA[i];
      bus.req_b[i*BW +: BW] = opB[i];
      bus.req_c[i*CW +: CW] = opC[i];
    end
  endtask

  function automatic logic [PW-1:0] modelP(input int i);
    longint full;
    full = longint'(opA[i]) * longint'(opB[i]) + longint'(opC[i]);
    return PW'(full);
  endfunction

  function automatic int expGrant();
    if (hold) return -1;
    for (int k = 1; k <= N; k++) begin
      int idx = (tbLast + k) % N;
      if (valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    expQ.delete();
    hist     = 2'b00;
    tbLast   = N - 1;
    lastId   = '0;
    lastP    = '0;
    expState = 2'(RUN);
`ifdef MAC_SHARE_PERF_CNT_EN
    for (int i = 0; i < N; i++) cntModel[i] = 16'd0;
`endif
  endtask

  // One clock: check grant before the edge, then the response side after it.
  task automatic tick(input string tag, output int gObs);
    int   gm;
    logic [N-1:0] expReady;
    logic busyNow;
    exp_t e;
    #1;
    gm = expGrant();
    expReady = '0;
    if (gm >= 0) expReady[gm] = 1'b1;
    checkOutput({tag, "/ready"}, 64'(bus.req_ready), 64'(expReady));
    gObs = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) gObs = i;
    busyNow = hist[0] | hist[1];
    if (!hold)        expState = 2'(RUN);
    else if (busyNow) expState = 2'(DRAIN);
    else              expState = 2'(IDLE_HELD);
    if (gm >= 0) begin
      e.id = IW'(gm);
      e.p  = modelP(gm);
      expQ.push_back(e);
      tbLast = gm;
    end
`ifdef MAC_SHARE_PERF_CNT_EN
    for (int i = 0; i < N; i++) begin
      if (cnt_clr)      cntModel[i] = 16'd0;
      else if (gm == i) cntModel[i] = cntModel[i] + 16'd1;
    end
`endif
    hist = {hist[0], gm >= 0};
    @(posedge clk);
    #1;
    checkOutput({tag, "/state"}, 64'(dut.state_q), 64'(expState));
    checkOutput({tag, "/busy"}, 64'(busy), 64'(hist[0] | hist[1]));
    checkOutput({tag, "/rsp_valid"}, 64'(bus.rsp_valid), 64'(hist[1]));
    if (hist[1] && expQ.size() > 0) begin
      e = expQ.pop_front();
      lastId = e.id;
      lastP  = e.p;
    end
    checkOutput({tag, "/rsp_id"}, 64'(bus.rsp_id), 64'(lastId));
    checkOutput({tag, "/rsp_p"}, 64'(bus.rsp_p), 64'(lastP));
`ifdef MAC_SHARE_PERF_CNT_EN
    for (int i = 0; i < N; i++)
      checkOutput({tag, "/cnt"}, 64'(grant_cnt[i*16 +: 16]), 64'(cntModel[i]));
`endif
  endtask

  // Async reset pulse taken between edges; outputs must clear immediately.
  task automatic doReset();
    valid = '0;
    applyStimulus();
    rst_n = 1'b0;
    #2;
    checkOutput("rst/ready", 64'(bus.req_ready), 64'(0));
    checkOutput("rst/rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("rst/rsp_id", 64'(bus.rsp_id), 64'(0));
    checkOutput("rst/rsp_p", 64'(bus.rsp_p), 64'(0));
    checkOutput("rst/busy", 64'(busy), 64'(0));
    checkOutput("rst/state", 64'(dut.state_q), 64'(RUN));
`ifdef MAC_SHARE_PERF_CNT_EN
    checkOutput("rst/cnt", 64'(grant_cnt), 64'(0));
`endif
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int g;
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    valid = '0;
    for (int i = 0; i < N; i++) begin
      opA[i] = '0;
      opB[i] = '0;
      opC[i] = '0;
    end
    applyStimulus();
    modelReset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    $display("[TB] single op");
    opA[0] = -16'sd3;
    opB[0] = 16'sd7;
    opC[0] = 32'sd100;
    valid  = 4'b0001;
    applyStimulus();
    tick("single0", g);
    valid = '0;
    applyStimulus();
    tick("single1", g);
    checkOutput("single/p79", 64'(bus.rsp_p), 64'(79));
    checkOutput("single/id0", 64'(bus.rsp_id), 64'(0));
    tick("single2", g);
    tick("single3", g);

    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < N; i++) begin
      opA[i] = AW'(100 * (i + 1) - 250);
      opB[i] = BW'(-37 * (i + 2));
      opC[i] = CW'(1000 * i - 1);
    end
    valid = 4'b1111;
    applyStimulus();
    for (int k = 0; k < 6; k++) begin
      tick("rr", g);
      checkOutput("rr/order", 64'(g), 64'(order[k]));
    end
    valid = '0;
    applyStimulus();
    tick("rr_drain", g);
    tick("rr_drain", g);

    $display("[TB] wrap");
    opA[1] = -16'sd32768;
    opB[1] = -16'sd32768;
    opC[1] = 32'sh7FFFFFFF;
    valid  = 4'b0010;
    applyStimulus();
    tick("wrap0", g);
    valid = '0;
    applyStimulus();
    tick("wrap1", g);
    checkOutput("wrap/p", 64'(bus.rsp_p), 64'(32'hBFFFFFFF));
    tick("wrap2", g);

    $display("[TB] random traffic");
    g = -1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid[i] || g == i) begin
          valid[i] = 1'($urandom_range(0, 1));
          opA[i]   = AW'($urandom);
          opB[i]   = BW'($urandom);
          opC[i]   = CW'($urandom);
        end
      end
      hold = ($urandom_range(0, 5) == 0);
      applyStimulus();
      tick("rand", g);
    end
    hold  = 1'b0;
    valid = '0;
    applyStimulus();
    for (int k = 0; k < 3; k++) tick("rand_drain", g);

    $display("[TB] hold and drain");
    valid = 4'b0010;
    applyStimulus();
    tick("hold_a", g);
    valid = 4'b0100;
    applyStimulus();
    tick("hold_b", g);
    hold  = 1'b1;
    valid = 4'b1111;
    applyStimulus();
    tick("hold_c", g);
    checkOutput("hold/drain", 64'(dut.state_q), 64'(DRAIN));
    tick("hold_d", g);
    tick("hold_e", g);
    checkOutput("hold/idle", 64'(dut.state_q), 64'(IDLE_HELD));
    hold = 1'b0;
    applyStimulus();
    tick("resume", g);
    checkOutput("resume/grant", 64'(g), 64'(3));
    valid = '0;
    applyStimulus();
    for (int k = 0; k < 3; k++) tick("hold_drain", g);

    $display("[TB] reset mid-flight");
    valid = 4'b1111;
    applyStimulus();
    tick("mid0", g);
    tick("mid1", g);
    doReset();
    for (int k = 0; k < 3; k++) tick("post_rst", g);
    valid = 4'b1111;
    applyStimulus();
    tick("post_rst_grant", g);
    checkOutput("post_rst/first", 64'(g), 64'(0));
    valid = '0;
    applyStimulus();
    for (int k = 0; k < 3; k++) tick("post_rst_drain", g);

`ifdef MAC_SHARE_PERF_CNT_EN
    $display("[TB] grant counters");
    doReset();
    valid = 4'b0100;
    applyStimulus();
    for (int k = 0; k < 5; k++) tick("cnt", g);
    checkOutput("cnt/five", 64'(grant_cnt[2*16 +: 16]), 64'(5));
    cnt_clr = 1'b1;
    tick("cnt_clr", g);
    checkOutput("cnt/cleared", 64'(grant_cnt[2*16 +: 16]), 64'(0));
    cnt_clr = 1'b0;
    valid = '0;
    applyStimulus();
    for (int k = 0; k < 3; k++) tick("cnt_drain", g);
`endif

    checkOutput("scoreboard/empty", 64'(expQ.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Shares one 2-stage signed multiply-add pipeline (p = a*b + c) between N_REQ requesters.
- Each requester offers operands on a valid/ready handshake. Round-robin arbitration grants at most one per cycle.
- Results return on a shared response bus tagged with the requester index.
- Sits between DSP-mapped MAC datapaths and their clients. A hold input lets the controller stop new issue and drain the pipeline.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- A_W, 16, signed width of a
- B_W, 16, signed width of b
- C_W, 32, signed width of c
- P_W, 32, signed width of result p

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- req_a  in  N_REQ*A_W  packed a operands; slice i = [i*A_W +: A_W]
- req_b  in  N_REQ*B_W  packed b operands
- req_c  in  N_REQ*C_W  packed c operands
- hold  in  1  1 = issue no new grants; in-flight ops still complete
- rsp_valid  out  1  result valid, single-cycle pulse per op; no backpressure
- rsp_id  out  $clog2(N_REQ)  requester index of the result
- rsp_p  out  P_W  signed result
- busy  out  1  high while any op is in flight in either stage

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, req_ready=0, stage valids=0, rr_last=N_REQ-1 (requester 0 has first priority).
- Grant is combinational and one-hot. When hold=0, req_ready[i]=1 for the first i with req_valid[i]=1, searching (rr_last+1) mod N_REQ upward with wrap. When hold=1 or no request is valid, req_ready=0.
- req_ready depends only on req_valid, rr_last and hold, never on the data inputs.
- On a handshake at edge k, rr_last <= granted index. With no handshake, rr_last holds.
- Arithmetic: sign-extend a and b, form the full product, add sign-extended c, keep the low P_W bits (two's-complement wrap, no saturation).
- Pipeline:
  - stage0 captures {valid, id, a*b+c} at handshake edge k;
  - stage1 captures stage0 at edge k+1;
  - rsp_* are driven from stage1, so rsp_valid is high for exactly the cycle after edge k+1.
  - Fixed latency of 2 edges. Throughput is one op per cycle.
- When rsp_valid=0, rsp_id and rsp_p hold their last value.
- busy = stage0.valid | stage1.valid.
- Control FSM, 2-bit:
  - RUN: grants allowed.
  - DRAIN: hold=1 and busy=1.
  - IDLE_HELD: hold=1 and busy=0.
  - RUN -> DRAIN when hold rises with ops in flight; RUN -> IDLE_HELD when hold rises with the pipeline empty.
  - DRAIN -> IDLE_HELD when busy falls.
  - Any state -> RUN when hold=0, and grants resume that same cycle.
  - FSM state is informational and drives no extra output; it is exposed only to assertions.
- Simultaneous requests: exactly one grant per cycle; non-granted requesters must keep valid and data stable.
- A requester that drops valid without a grant is legal; nothing is issued for it.
- Reset mid-operation discards in-flight ops; no rsp_valid is produced for them.

Optional Feature:
- Macro: MAC_SHARE_PERF_CNT_EN.
- Defined: adds output grant_cnt, N_REQ*16 bits. 16-bit per-requester counters increment on each handshake, wrap at 0xFFFF, and reset to 0.
- Also adds input cnt_clr, 1 bit: synchronous clear of all counters. If a handshake coincides with cnt_clr, the cleared value (0) wins.
- Undefined: these ports and all counter logic are absent.

Decomposition:
- Package mac_share_pkg: default widths, the FSM state enum (RUN, DRAIN, IDLE_HELD) and the id width function.
- One sub-module, signed_mac_pipe: the 2-stage signed a*b+c pipeline with valid/id sideband, parameterised by widths.
- Arbitration, FSM and counters stay in the top module.

Test Plan:
1. Single op: req0 a=-3, b=7, c=100 -> rsp_valid 2 edges later with rsp_id=0, rsp_p=79; busy high for exactly those 2 cycles.
2. All four requesters valid continuously after reset -> grants in order 0,1,2,3,0,…; back-to-back rsp_valid; each rsp_p matches its operands.
3. Wrap: a=-32768, b=-32768, c=0x7FFFFFFF -> rsp_p = 0x40000000 + 0x7FFFFFFF mod 2^32 = 0xBFFFFFFF.
4. hold asserted with 2 ops in flight -> req_ready=0 immediately; both results still emerge; FSM goes DRAIN -> IDLE_HELD; on hold release the grant goes to rr_last+1.
5. rst_n pulsed low while stage0 and stage1 are valid -> no rsp_valid afterwards; next grant goes to requester 0.
6. With MAC_SHARE_PERF_CNT_EN: 5 grants to req2, then cnt_clr coincident with a req2 handshake -> grant_cnt[2]=0 on the next cycle.
